// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: word size, op codes,
// instruction field positions and controller state encodings.
package alu_issue_ctrl_pkg;

    localparam int WORDSIZE = 16;
    localparam int NREGS    = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    // Instruction layout: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS1_HI = 3;
    localparam int RS1_LO = 2;
    localparam int RS2_HI = 1;
    localparam int RS2_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// 4-entry register file: two combinational read ports, two write ports where
// port 0 (write-back) beats port 1 (external load) on an address collision.
module alu_issue_ctrl_regfile
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = WORDSIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       rd_addr0,
    output logic [WIDTH-1:0] rd_data0,
    input  logic [1:0]       rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    input  logic             wr_en0,
    input  logic [1:0]       wr_addr0,
    input  logic [WIDTH-1:0] wr_data0,
    input  logic             wr_en1,
    input  logic [1:0]       wr_addr1,
    input  logic [WIDTH-1:0] wr_data1
);

    logic [WIDTH-1:0] regs [NREGS];

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
        localparam logic [1:0] IDX = 2'(gi);
        logic [WIDTH-1:0] entry_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_reg <= '0;
            end else if (wr_en0 && (wr_addr0 == IDX)) begin
                entry_reg <= wr_data0;
            end else if (wr_en1 && (wr_addr1 == IDX)) begin
                entry_reg <= wr_data1;
            end
        end

        assign regs[gi] = entry_reg;
    end

    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational ALU: accepts an instruction,
// reads operands, presents them to the ALU, captures and writes back the result.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = WORDSIZE,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [7:0]       instr,
    input  logic             ext_wr_en,
    input  logic [1:0]       ext_wr_addr,
    input  logic [WIDTH-1:0] ext_wr_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    input  logic [WIDTH-1:0] alu_y,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       res_rd
);

    state_t           state_reg;
    logic [7:0]       instr_reg;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             wb_en;

    assign instr_ready = (state_reg == ST_IDLE);
    assign wb_en       = (state_reg == ST_WB);

    alu_issue_ctrl_regfile #(
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr0 (instr_reg[RS1_HI:RS1_LO]),
        .rd_data0 (rs1_data),
        .rd_addr1 (instr_reg[RS2_HI:RS2_LO]),
        .rd_data1 (rs2_data),
        .wr_en0   (wb_en),
        .wr_addr0 (res_rd),
        .wr_data0 (res_data),
        .wr_en1   (ext_wr_en),
        .wr_addr1 (ext_wr_addr),
        .wr_data1 (ext_wr_data)
    );

    // ALU operands move only on the READ edge so they stay stable through EXEC and WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            instr_reg <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            res_data  <= '0;
            res_rd    <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_reg <= instr;
                        state_reg <= ST_READ;
                    end
                end
                ST_READ: begin
                    alu_a     <= rs1_data;
                    alu_b     <= rs2_data;
                    alu_s     <= instr_reg[OP_HI:OP_LO];
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_data  <= alu_y;
                    res_rd    <= instr_reg[RD_HI:RD_LO];
                    res_valid <= 1'b1;
                    state_reg <= ST_WB;
                end
                ST_WB: begin
                    res_valid <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    res_valid <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized scoreboard bench for alu_issue_ctrl with a bench-side ALU and a
// transaction-level register file model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr;
    logic        ext_wr_en;
    logic [1:0]  ext_wr_addr;
    logic [15:0] ext_wr_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_s;
    logic [15:0] alu_y;
    logic        res_valid;
    logic [15:0] res_data;
    logic [1:0]  res_rd;

    int ncmp  = 0;
    int nfail = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  s;
        logic [1:0]  rd;
        logic [15:0] y;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mreg [4];
    bit          prev_hold = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ext_wr_en   (ext_wr_en),
        .ext_wr_addr (ext_wr_addr),
        .ext_wr_data (ext_wr_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_s       (alu_s),
        .alu_y       (alu_y),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_rd      (res_rd)
    );

    function automatic logic [15:0] ref_alu(logic [1:0] op, logic [15:0] a, logic [15:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    // The parent-side combinational ALU
    always_comb alu_y = ref_alu(alu_s, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every result strobe is matched against the oldest expected result
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (exp_q.size() == 0) begin
                ncmp++;
                nfail++;
                $display("FAIL unexpected_res: res_valid with no pending instruction at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("result rd=%0d data=0x%04h (exp rd=%0d data=0x%04h)", res_rd, res_data, e.rd, e.y);
                chk("res_data", 32'(res_data), 32'(e.y));
                chk("res_rd", 32'(res_rd), 32'(e.rd));
                chk("alu_a", 32'(alu_a), 32'(e.a));
                chk("alu_b", 32'(alu_b), 32'(e.b));
                chk("alu_s", 32'(alu_s), 32'(e.s));
            end
        end
    end

    task automatic wait_ready(output int waited);
        waited = 0;
        @(negedge clk);
        ext_wr_en   = 1'b0;
        instr_valid = 1'b0;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            ncmp++;
            nfail++;
            $display("FAIL ready_timeout: instr_ready stayed 0 for %0d cycles", waited);
        end
    endtask

    task automatic ext_load(input logic [1:0] addr, input logic [15:0] data);
        @(negedge clk);
        instr_valid = 1'b0;
        ext_wr_en   = 1'b1;
        ext_wr_addr = addr;
        ext_wr_data = data;
        mreg[addr]  = data;
        $display("ext_load r%0d=0x%04h", addr, data);
        @(negedge clk);
        ext_wr_en = 1'b0;
    endtask

    // Issue one instruction; an optional external write lands at edge accept+ph
    task automatic do_instr(input logic [7:0] ins, input bit hold, input bit en,
                            input logic [1:0] ea, input logic [15:0] ed, input int ph);
        int   waited;
        exp_t e;
        wait_ready(waited);
        if (prev_hold) chk("b2b_accept_gap", 32'(waited), 32'd0);
        if (en && ph == 0) mreg[ea] = ed;
        e.a  = mreg[ins[3:2]];
        e.b  = mreg[ins[1:0]];
        e.s  = ins[7:6];
        e.rd = ins[5:4];
        e.y  = ref_alu(e.s, e.a, e.b);
        if (en && ph != 0) mreg[ea] = ed;
        mreg[e.rd] = e.y;
        exp_q.push_back(e);
        $display("issue instr=0x%02h hold=%0d ext=%0d r%0d=0x%04h ph=%0d", ins, hold, en, ea, ed, ph);
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                chk("ready_busy", 32'(instr_ready), 32'd0);
            end
            chk("res_valid_timing", 32'(res_valid), (cyc == 3) ? 32'd1 : 32'd0);
            instr_valid = (cyc == 0) || hold;
            instr       = ins;
            ext_wr_en   = en && (ph == cyc);
            ext_wr_addr = ea;
            ext_wr_data = ed;
        end
        prev_hold = hold;
    endtask

    initial begin
        int waited;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        ext_wr_en   = 1'b0;
        ext_wr_addr = '0;
        ext_wr_data = '0;
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_s", 32'(alu_s), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_rd", 32'(res_rd), 32'd0);
        rst_n = 1'b1;

        // Basic ops
        ext_load(2'd1, 16'h0005);
        ext_load(2'd2, 16'h0003);
        do_instr(8'h06, 0, 0, 2'd0, 16'h0, 0);
        do_instr(8'h79, 0, 0, 2'd0, 16'h0, 0);
        do_instr(8'h8D, 0, 0, 2'd0, 16'h0, 0);
        do_instr(8'hCD, 0, 0, 2'd0, 16'h0, 0);

        // Held valid, dependent back-to-back pair
        ext_load(2'd1, 16'h0005);
        ext_load(2'd2, 16'h0003);
        do_instr(8'h06, 1, 0, 2'd0, 16'h0, 0);
        do_instr(8'h31, 0, 0, 2'd0, 16'h0, 0);

        // Ext write in the WB cycle: same target (dropped) and other target (kept)
        do_instr(8'h06, 0, 1, 2'd0, 16'h1234, 3);
        do_instr(8'hF0, 0, 0, 2'd0, 16'h0, 0);
        do_instr(8'h06, 0, 1, 2'd2, 16'h1234, 3);
        do_instr(8'hF0, 0, 0, 2'd0, 16'h0, 0);
        do_instr(8'hFA, 0, 0, 2'd0, 16'h0, 0);

        // Reset during EXEC
        wait_ready(waited);
        instr_valid = 1'b1;
        instr       = 8'h06;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("reset asserted during EXEC");
        chk("mid_rst_ready", 32'(instr_ready), 32'd1);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
        chk("mid_rst_alu_s", 32'(alu_s), 32'd0);
        chk("mid_rst_res_data", 32'(res_data), 32'd0);
        chk("mid_rst_res_rd", 32'(res_rd), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_res_after_abort", 32'(res_valid), 32'd0);
        end
        do_instr(8'hC6, 0, 0, 2'd0, 16'h0, 0);
        do_instr(8'hFF, 0, 0, 2'd0, 16'h0, 0);
        do_instr(8'hF0, 0, 0, 2'd0, 16'h0, 0);

        // Overflow and aliased operands
        ext_load(2'd1, 16'hFFFF);
        ext_load(2'd2, 16'h0001);
        do_instr(8'h06, 0, 0, 2'd0, 16'h0, 0);
        ext_load(2'd1, 16'h0002);
        do_instr(8'h15, 0, 0, 2'd0, 16'h0, 0);

        // Randomized traffic with ext writes at every phase
        for (int n = 0; n < 60; n++) begin
            bit hold;
            if (!prev_hold && $urandom_range(0, 3) == 0)
                ext_load(2'($urandom_range(0, 3)), 16'($urandom));
            hold = (n != 59) && ($urandom_range(0, 2) == 0);
            do_instr(8'($urandom), hold, 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        instr_valid = 1'b0;
        ext_wr_en   = 1'b0;
        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end

endmodule
